// File: rtl/stopwatch_pkg.sv
//==============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch/timer datapath:
//               FSM state encoding, field limits, the time-of-count struct and
//               a load-value saturation helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Field widths of the shared time struct. Instances use the low FW/HW
    // bits; the upper bits stay zero because every field is bounded.
    localparam int FRAC_W_MAX = 16;
    localparam int HOUR_W_MAX = 8;

    typedef struct packed {
        logic [HOUR_W_MAX-1:0] hour;
        logic [5:0]            min;
        logic [5:0]            sec;
        logic [FRAC_W_MAX-1:0] frac;
    } time_t;

    // Clamp a 6-bit minute/second preset to 0..59.
    function automatic logic [5:0] sat_field(input logic [5:0] v);
        return (v > 6'(SEC_MAX)) ? 6'(SEC_MAX) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_timer_dp_tick_prescaler.sv
//==============================================================================
// Module      : tick_prescaler
// Description : Divides the system clock down to the fraction tick rate.
//               Counts 0..DIV-1 while en is high, holds otherwise.
// Ports       : clk      - system clock
//               rst      - asynchronous active-low reset
//               en       - count enable (high only in RUN)
//               sync_clr - synchronous restart to 0
//               tick     - high in the enabled cycle where the count is DIV-1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == c_last);
    assign tick   = en && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/stopwatch_timer_dp.sv
//==============================================================================
// Module      : stopwatch_timer_dp
// Description : hh:mm:ss:frac stopwatch / countdown timer datapath with lap
//               capture, countdown-done and up-count wrap pulses.
// Ports       : clk, rst (async active-low)
//               run (level), clear/load/lap (1-cycle pulses), mode (0 up,
//               1 down), load_min/load_sec (presets)
//               frac/sec/min/hour     - current time
//               lap_* / lap_valid     - captured time
//               done / wrap           - one-cycle event pulses
// Options     : STOPWATCH_LAP_EN - builds the lap register; when undefined
//               the lap input is ignored and lap outputs are tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module stopwatch_timer_dp
    import stopwatch_pkg::*;
#(
    parameter  int CLK_FREQ_HZ = 100_000_000,
    parameter  int TICK_HZ     = 100,
    parameter  int HOUR_MAX    = 24,
    localparam int FW          = $clog2(TICK_HZ),
    localparam int HW          = $clog2(HOUR_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clear,
    input  logic          mode,
    input  logic          load,
    input  logic [5:0]    load_min,
    input  logic [5:0]    load_sec,
    input  logic          lap,
    output logic [FW-1:0] frac,
    output logic [5:0]    sec,
    output logic [5:0]    min,
    output logic [HW-1:0] hour,
    output logic [FW-1:0] lap_frac,
    output logic [5:0]    lap_sec,
    output logic [5:0]    lap_min,
    output logic [HW-1:0] lap_hour,
    output logic          lap_valid,
    output logic          done,
    output logic          wrap
);

    localparam logic [FRAC_W_MAX-1:0] c_frac_top = FRAC_W_MAX'(TICK_HZ - 1);
    localparam logic [HOUR_W_MAX-1:0] c_hour_top = HOUR_W_MAX'(HOUR_MAX - 1);
    localparam logic [5:0]            c_sec_top  = 6'(SEC_MAX);
    localparam logic [5:0]            c_min_top  = 6'(MIN_MAX);

    state_t r_state, w_state_nxt;
    time_t  r_time, w_time_inc, w_time_dec, w_time_nxt;
    logic   r_mode, r_done, r_wrap;
    logic   w_tick, w_pre_clr, w_to_done;
    logic   w_frac_top, w_sec_top, w_min_top, w_hour_top;
    logic   w_frac_bot, w_sec_bot, w_min_bot, w_hour_bot;
    logic   w_time_zero, w_time_max, w_dec_zero;

    tick_prescaler #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (r_state == RUN),
        .sync_clr (w_pre_clr),
        .tick     (w_tick)
    );

    assign w_frac_top = (r_time.frac == c_frac_top);
    assign w_sec_top  = (r_time.sec  == c_sec_top);
    assign w_min_top  = (r_time.min  == c_min_top);
    assign w_hour_top = (r_time.hour == c_hour_top);
    assign w_frac_bot = (r_time.frac == '0);
    assign w_sec_bot  = (r_time.sec  == '0);
    assign w_min_bot  = (r_time.min  == '0);
    assign w_hour_bot = (r_time.hour == '0);

    assign w_time_zero = (r_time == '0);
    assign w_time_max  = w_frac_top && w_sec_top && w_min_top && w_hour_top;
    assign w_dec_zero  = (w_time_dec == '0);

    // Full ripple of carries/borrows in one cycle: each stage rolls only
    // when every lower stage is at its limit.
    always_comb begin
        w_time_inc = r_time;
        w_time_dec = r_time;

        w_time_inc.frac = w_frac_top ? '0 : r_time.frac + FRAC_W_MAX'(1);
        if (w_frac_top)
            w_time_inc.sec = w_sec_top ? '0 : r_time.sec + 6'd1;
        if (w_frac_top && w_sec_top)
            w_time_inc.min = w_min_top ? '0 : r_time.min + 6'd1;
        if (w_frac_top && w_sec_top && w_min_top)
            w_time_inc.hour = w_hour_top ? '0 : r_time.hour + HOUR_W_MAX'(1);

        w_time_dec.frac = w_frac_bot ? c_frac_top : r_time.frac - FRAC_W_MAX'(1);
        if (w_frac_bot)
            w_time_dec.sec = w_sec_bot ? c_sec_top : r_time.sec - 6'd1;
        if (w_frac_bot && w_sec_bot)
            w_time_dec.min = w_min_bot ? c_min_top : r_time.min - 6'd1;
        if (w_frac_bot && w_sec_bot && w_min_bot)
            w_time_dec.hour = w_hour_bot ? c_hour_top : r_time.hour - HOUR_W_MAX'(1);
    end

    // Next state. A load cycle suppresses the tick, so it can neither start
    // the count from IDLE nor complete a countdown.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!load && run)
                             w_state_nxt = (mode && w_time_zero) ? DONE : RUN;
                RUN:     if (!load && w_tick && r_mode && w_dec_zero)
                             w_state_nxt = DONE;
                         else if (!run)
                             w_state_nxt = PAUSE;
                PAUSE:   if (run) w_state_nxt = RUN;
                DONE:    if (load) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_to_done = (w_state_nxt == DONE) && (r_state != DONE);
    assign w_pre_clr = clear || load || w_to_done;

    always_comb begin
        w_time_nxt = r_time;
        if (clear) begin
            w_time_nxt = '0;
        end else if (load) begin
            w_time_nxt     = '0;
            w_time_nxt.min = sat_field(load_min);
            w_time_nxt.sec = sat_field(load_sec);
        end else if (w_tick) begin
            w_time_nxt = r_mode ? w_time_dec : w_time_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_time  <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
            if ((r_state == IDLE || r_state == PAUSE) && w_state_nxt == RUN)
                r_mode <= mode;
            r_done  <= w_to_done;
            r_wrap  <= !clear && !load && w_tick && !r_mode && w_time_max;
        end
    end

    assign frac = r_time.frac[FW-1:0];
    assign sec  = r_time.sec;
    assign min  = r_time.min;
    assign hour = r_time.hour[HW-1:0];
    assign done = r_done;
    assign wrap = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic [FW-1:0] r_lap_frac;
    logic [5:0]    r_lap_sec;
    logic [5:0]    r_lap_min;
    logic [HW-1:0] r_lap_hour;
    logic          r_lap_valid;

    // Captures r_time before this edge's update, so a lap on a tick cycle
    // records the pre-tick value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_frac  <= '0;
            r_lap_sec   <= '0;
            r_lap_min   <= '0;
            r_lap_hour  <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_frac  <= '0;
            r_lap_sec   <= '0;
            r_lap_min   <= '0;
            r_lap_hour  <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap) begin
            r_lap_frac  <= r_time.frac[FW-1:0];
            r_lap_sec   <= r_time.sec;
            r_lap_min   <= r_time.min;
            r_lap_hour  <= r_time.hour[HW-1:0];
            r_lap_valid <= 1'b1;
        end
    end

    assign lap_frac  = r_lap_frac;
    assign lap_sec   = r_lap_sec;
    assign lap_min   = r_lap_min;
    assign lap_hour  = r_lap_hour;
    assign lap_valid = r_lap_valid;
`else
    logic w_lap_unused;
    assign w_lap_unused = lap;

    assign lap_frac  = '0;
    assign lap_sec   = '0;
    assign lap_min   = '0;
    assign lap_hour  = '0;
    assign lap_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer_dp.sv
//==============================================================================
// Module      : tb_stopwatch_timer_dp
// Description : Directed self-checking bench for stopwatch_timer_dp with
//               CLK_FREQ_HZ=1000, TICK_HZ=10 (DIV=100), HOUR_MAX=24.
//               Lap expectations follow STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stopwatch_timer_dp;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_EN
    localparam int LAP_EN = 1;
`else
    localparam int LAP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic       lap = 1'b0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic [3:0] frac, lap_frac;
    logic [5:0] sec, min, lap_sec, lap_min;
    logic [4:0] hour, lap_hour;
    logic       lap_valid, done, wrap;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wrap_cnt = 0;
    int d0, w0;

    stopwatch_timer_dp #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (10),
        .HOUR_MAX    (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .mode      (mode),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .lap       (lap),
        .frac      (frac),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .lap_frac  (lap_frac),
        .lap_sec   (lap_sec),
        .lap_min   (lap_min),
        .lap_hour  (lap_hour),
        .lap_valid (lap_valid),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wrap) wrap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int f);
        chk({tag, "_hour"}, 32'(hour), h);
        chk({tag, "_min"},  32'(min),  m);
        chk({tag, "_sec"},  32'(sec),  s);
        chk({tag, "_frac"}, 32'(frac), f);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk_time("reset", 0, 0, 0, 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_wrap", 32'(wrap), 0);
        chk("reset_lap_valid", 32'(lap_valid), 0);
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Up count: entry edge, then a tick every 100 cycles
        mode = 1'b0; run = 1'b1; w0 = wrap_cnt;
        step(1000);
        chk_time("up_999", 0, 0, 0, 9);
        step(1);
        chk_time("up_1s", 0, 0, 1, 0);
        chk("up_no_wrap", 32'(wrap_cnt - w0), 0);

        // Pause / resume with prescaler mid-count
        run = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk_time("clear", 0, 0, 0, 0);
        chk("clear_state", 32'(dut.r_state), 32'(IDLE));
        run = 1'b1;
        step(250);
        chk("pause_pre", 32'(frac), 2);
        run = 1'b0;
        step(500);
        chk("pause_hold", 32'(frac), 2);
        chk("pause_state", 32'(dut.r_state), 32'(PAUSE));
        run = 1'b1;
        step(50);
        chk("resume_49", 32'(frac), 2);
        step(1);
        chk("resume_tick", 32'(frac), 3);

        // Countdown from 0:00:01:0
        run = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;
        load = 1'b1; load_min = 6'd0; load_sec = 6'd1;
        step(1);
        load = 1'b0;
        chk_time("load", 0, 0, 1, 0);
        mode = 1'b1; run = 1'b1; d0 = done_cnt;
        step(1000);
        chk_time("down_pre", 0, 0, 0, 1);
        chk("down_pre_done", 32'(done), 0);
        step(1);
        chk_time("down_zero", 0, 0, 0, 0);
        chk("down_done", 32'(done), 1);
        chk("down_state", 32'(dut.r_state), 32'(DONE));
        step(300);
        chk("done_hold_state", 32'(dut.r_state), 32'(DONE));
        chk("done_hold_frac", 32'(frac), 0);
        chk("done_pulses", 32'(done_cnt - d0), 1);

        // IDLE with zero time and mode=1 goes straight to DONE
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("idle_after_clear", 32'(dut.r_state), 32'(IDLE));
        step(1);
        chk("idle_zero_state", 32'(dut.r_state), 32'(DONE));
        chk("idle_zero_done", 32'(done), 1);

        // Load in DONE returns to IDLE; out-of-range minute saturates
        run = 1'b0; load = 1'b1; load_min = 6'd61; load_sec = 6'd5;
        step(1);
        load = 1'b0;
        chk("load_done_state", 32'(dut.r_state), 32'(IDLE));
        chk_time("load_sat", 0, 59, 5, 0);

        // Rollover: borrow from zero to 23:59:59:9, then count up
        clear = 1'b1;
        step(1);
        clear = 1'b0; mode = 1'b0; run = 1'b1;
        step(10);
        run = 1'b0;
        step(1);
        mode = 1'b1; run = 1'b1; d0 = done_cnt;
        step(90);
        chk_time("borrow_pre", 0, 0, 0, 0);
        step(1);
        chk_time("borrow_max", 23, 59, 59, 9);
        chk("borrow_no_done", 32'(done_cnt - d0), 0);
        run = 1'b0;
        step(1);
        mode = 1'b0; run = 1'b1; w0 = wrap_cnt;
        step(99);
        chk_time("wrap_pre", 23, 59, 59, 9);
        chk("wrap_pre_flag", 32'(wrap), 0);
        step(1);
        chk_time("wrap_zero", 0, 0, 0, 0);
        chk("wrap_flag", 32'(wrap), 1);
        step(1);
        chk("wrap_one_cycle", 32'(wrap), 0);
        chk("wrap_pulses", 32'(wrap_cnt - w0), 1);

        // Lap on the frac 4->5 tick cycle captures the pre-tick value
        step(498);
        chk("lap_pre_frac", 32'(frac), 4);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        chk("lap_post_frac", 32'(frac), 5);
        chk("lap_frac", 32'(lap_frac), LAP_EN ? 4 : 0);
        chk("lap_valid", 32'(lap_valid), LAP_EN);
        chk("lap_sec", 32'(lap_sec), 0);
        clear = 1'b1; run = 1'b0;
        step(1);
        clear = 1'b0;
        chk("lap_clr_valid", 32'(lap_valid), 0);
        chk("lap_clr_frac", 32'(lap_frac), 0);

        // clear beats load on the same cycle
        load = 1'b1; clear = 1'b1; load_min = 6'd5; load_sec = 6'd6;
        step(1);
        load = 1'b0; clear = 1'b0;
        chk_time("clr_over_load", 0, 0, 0, 0);

        // Asynchronous reset mid-count
        mode = 1'b0; run = 1'b1;
        step(350);
        chk("mid_frac", 32'(frac), 3);
        rst = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0, 0);
        chk("async_rst_state", 32'(dut.r_state), 32'(IDLE));
        @(posedge clk);
        #1 rst = 1'b1;
        step(100);
        chk("post_rst_pre", 32'(frac), 0);
        step(1);
        chk("post_rst_tick", 32'(frac), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
